life_sequencer: RTL

LIFE_SEQUENCER -- requirements
Module: life_sequencer

---
 rtl/life_pkg.sv | 19 +
 rtl/life_row_scan.sv | 36 +++
 rtl/life_sequencer.sv | 93 +++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared board geometry and sequencer state encoding for the Life display block.
package life_pkg;

    localparam int BOARD_ROWS = 8;
    localparam int BOARD_COLS = 8;
    localparam int BOARD_BITS = BOARD_ROWS * BOARD_COLS;
    localparam int ROW_W      = $clog2(BOARD_ROWS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } life_state_t;

    function automatic logic [BOARD_ROWS-1:0] row_onehot(input logic [ROW_W-1:0] row);
        return {{(BOARD_ROWS-1){1'b0}}, 1'b1} << row;
    endfunction

endpackage

// File: rtl/life_row_scan.sv
// Multiplexed LED row scanner: steps through the board rows, holding each for SCAN_CYCLES clocks.
module life_row_scan
    import life_pkg::*;
#(
    parameter int SCAN_CYCLES = 1200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BOARD_BITS-1:0] board,
    output logic [BOARD_ROWS-1:0] row_sel,
    output logic [BOARD_COLS-1:0] col_data
);

    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

    logic [SCAN_W-1:0] scan_cnt;
    logic [ROW_W-1:0]  row;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            row      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            row      <= row + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Column data follows the live board so a fresh capture shows up immediately.
    assign row_sel  = row_onehot(row);
    assign col_data = board[row*BOARD_COLS +: BOARD_COLS];

endmodule

// File: rtl/life_sequencer.sv
// Generation sequencer: hands the board to an external rule stage, captures the result,
// and drives a scanned LED matrix from the current board.
module life_sequencer
    import life_pkg::*;
#(
    parameter int TICK_CYCLES = 12000000,
    parameter int SCAN_CYCLES = 1200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  seed_valid,
    input  logic [BOARD_BITS-1:0] seed_bits,
    output logic                  seed_ready,
    input  logic                  run,
    input  logic                  step,
    input  logic [BOARD_BITS-1:0] next_bits,
    output logic                  update,
    output logic [BOARD_BITS-1:0] current_bits,
    output logic [15:0]           gen_count,
    output logic                  stable,
    output logic [BOARD_ROWS-1:0] row_sel,
    output logic [BOARD_COLS-1:0] col_data
);

    localparam int TICK_W = $clog2(TICK_CYCLES);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    life_state_t       state, state_nxt;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick_last;
    logic              seed_fire;

    assign tick_last  = (tick_cnt == TICK_LAST);
    assign seed_ready = (state == ST_IDLE);
    assign seed_fire  = seed_valid && seed_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // A seed in the same cycle as a start request wins; the start is dropped, not deferred.
    always_comb begin
        state_nxt = state;
        update    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!seed_fire && ((run && tick_last) || (step && !run)))
                    state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                update    = 1'b1;
                state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Tick holds its value while a generation is in flight with run still high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        tick_cnt <= '0;
        else if (seed_fire || !run)       tick_cnt <= '0;
        else if (state == ST_IDLE)        tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current_bits <= '0;
            gen_count    <= '0;
            stable       <= 1'b0;
        end else if (seed_fire) begin
            current_bits <= seed_bits;
            gen_count    <= '0;
            stable       <= 1'b0;
        end else if (state == ST_CAPTURE) begin
            current_bits <= next_bits;
            gen_count    <= gen_count + 16'd1;
            stable       <= (next_bits == current_bits);
        end
    end

    life_row_scan #(
        .SCAN_CYCLES(SCAN_CYCLES)
    ) u_scan (
        .clk     (clk),
        .reset   (reset),
        .board   (current_bits),
        .row_sel (row_sel),
        .col_data(col_data)
    );

endmodule
